pong_game_ctrl: RTL and testbench

Top-level game sequencer for the LED-matrix Pong. It owns the round state machine and drives the `playing` enable consumed by both paddle blocks and the ball block. It also generates the paddle and ball movement ticks from the system clock, issues serve pulses, and keeps score up to a configurable winning score. Paddles and the ball are pure datapaths; this block decides when they run, reset and restart.

---
 rtl/pong_game_ctrl.sv | 153 +++++++++++++++
 tb/tb_pong_game_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// Round sequencer for the LED-matrix Pong game.
// Generates movement ticks, serve pulses and keeps score.
module pong_game_ctrl #(
    parameter int TICK_DIV    = 2500000,
    parameter int WIN_SCORE   = 7,
    parameter int PAUSE_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnStart,
    input  logic       missA,
    input  logic       missB,
    output logic       playing,
    output logic       padTick,
    output logic       ballTick,
    output logic       serve,
    output logic       serveB,
    output logic [3:0] scoreA,
    output logic [3:0] scoreB,
    output logic [1:0] winner
);

    localparam int DW = $clog2(TICK_DIV);
    localparam int PW = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        PLAY,
        POINT,
        OVER
    } state_t;

    state_t        state;
    logic [DW-1:0] divCnt;
    logic          tick;
    logic [PW-1:0] pauseCnt;
    logic          btnPrev;
    logic          startReq;
    logic          missAReq;
    logic          missBReq;
    logic          lastB;

    // Free-running prescaler; never disturbed by round state
    always_ff @(posedge clk) begin
        if (rst) begin
            divCnt <= '0;
            tick   <= 1'b0;
        end else begin
            tick <= (divCnt == DW'(TICK_DIV - 1));
            if (divCnt == DW'(TICK_DIV - 1))
                divCnt <= '0;
            else
                divCnt <= divCnt + 1'b1;
        end
    end

    // Register inputs; button edge and misses act one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            btnPrev  <= 1'b0;
            startReq <= 1'b0;
            missAReq <= 1'b0;
            missBReq <= 1'b0;
        end else begin
            btnPrev  <= btnStart;
            startReq <= btnPrev & ~btnStart;
            missAReq <= missA & (state == PLAY);
            missBReq <= missB & (state == PLAY);
        end
    end

    // Round state machine with score, serve and winner registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pauseCnt <= '0;
            serve    <= 1'b0;
            serveB   <= 1'b0;
            scoreA   <= 4'd0;
            scoreB   <= 4'd0;
            winner   <= 2'b00;
            lastB    <= 1'b0;
        end else begin
            serve <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (startReq) begin
                        state    <= SERVE;
                        pauseCnt <= '0;
                    end
                end
                SERVE: begin
                    if (tick) begin
                        if (pauseCnt == PW'(PAUSE_TICKS - 1)) begin
                            state <= PLAY;
                            serve <= 1'b1;
                        end else begin
                            pauseCnt <= pauseCnt + 1'b1;
                        end
                    end
                end
                PLAY: begin
                    if (missAReq && missBReq) begin
                        state    <= SERVE;
                        pauseCnt <= '0;
                    end else if (missAReq) begin
                        state  <= POINT;
                        scoreB <= scoreB + 4'd1;
                        serveB <= 1'b0;
                        lastB  <= 1'b1;
                    end else if (missBReq) begin
                        state  <= POINT;
                        scoreA <= scoreA + 4'd1;
                        serveB <= 1'b1;
                        lastB  <= 1'b0;
                    end
                end
                POINT: begin
                    if (lastB && scoreB == 4'(WIN_SCORE)) begin
                        state  <= OVER;
                        winner <= 2'b10;
                    end else if (!lastB && scoreA == 4'(WIN_SCORE)) begin
                        state  <= OVER;
                        winner <= 2'b01;
                    end else begin
                        state    <= SERVE;
                        pauseCnt <= '0;
                    end
                end
                OVER: begin
                    if (startReq) begin
                        state  <= IDLE;
                        scoreA <= 4'd0;
                        scoreB <= 4'd0;
                        winner <= 2'b00;
                        serveB <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Enables decoded from registered state and tick only
    always_comb begin
        playing  = (state == SERVE) || (state == PLAY) ||
                   (state == POINT);
        padTick  = tick && ((state == SERVE) || (state == PLAY));
        ballTick = tick && (state == PLAY);
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed table,
// corner sequences and random play against a reference model.
module tb_pong_game_ctrl;

    localparam int TD = 4;
    localparam int WS = 3;
    localparam int PT = 2;

    localparam int S_IDLE  = 0;
    localparam int S_SERVE = 1;
    localparam int S_PLAY  = 2;
    localparam int S_POINT = 3;
    localparam int S_OVER  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btnStart = 1'b0;
    logic       missA = 1'b0;
    logic       missB = 1'b0;
    logic       playing, padTick, ballTick, serve, serveB;
    logic [3:0] scoreA, scoreB;
    logic [1:0] winner;

    pong_game_ctrl #(
        .TICK_DIV   (TD),
        .WIN_SCORE  (WS),
        .PAUSE_TICKS(PT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btnStart(btnStart),
        .missA   (missA),
        .missB   (missB),
        .playing (playing),
        .padTick (padTick),
        .ballTick(ballTick),
        .serve   (serve),
        .serveB  (serveB),
        .scoreA  (scoreA),
        .scoreB  (scoreB),
        .winner  (winner)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int nserve = 0;

    // Reference model: tick phase from edge count since reset,
    // game rules applied to events seen on the previous edge.
    int       m_st, k, m_pause, m_sa, m_sb;
    bit       m_side, m_lastB, m_serve;
    bit       m_pb, m_pstart, m_pa, m_pbm;
    bit [1:0] m_win;

    function automatic bit m_tick();
        return (k > 0) && (k % TD == 0);
    endfunction

    task automatic model_edge(bit r, bit b, bit ma, bit mb);
        bit t;
        int st;
        bit nstart, na, nb;
        if (r) begin
            m_st = S_IDLE; k = 0; m_pause = 0;
            m_sa = 0; m_sb = 0; m_side = 0; m_lastB = 0;
            m_serve = 0; m_win = 0;
            m_pb = 0; m_pstart = 0; m_pa = 0; m_pbm = 0;
            return;
        end
        t = m_tick();
        st = m_st;
        nstart = m_pb && !b;
        na = ma && (st == S_PLAY);
        nb = mb && (st == S_PLAY);
        m_serve = 0;
        case (st)
            S_IDLE:
                if (m_pstart) begin
                    m_st = S_SERVE; m_pause = 0;
                end
            S_SERVE:
                if (t) begin
                    m_pause++;
                    if (m_pause == PT) begin
                        m_st = S_PLAY; m_serve = 1;
                    end
                end
            S_PLAY:
                if (m_pa && m_pbm) begin
                    m_st = S_SERVE; m_pause = 0;
                end else if (m_pa) begin
                    m_sb++; m_side = 0; m_lastB = 1; m_st = S_POINT;
                end else if (m_pbm) begin
                    m_sa++; m_side = 1; m_lastB = 0; m_st = S_POINT;
                end
            S_POINT:
                if ((m_lastB ? m_sb : m_sa) == WS) begin
                    m_st = S_OVER;
                    m_win = m_lastB ? 2'b10 : 2'b01;
                end else begin
                    m_st = S_SERVE; m_pause = 0;
                end
            default:
                if (m_pstart) begin
                    m_st = S_IDLE; m_sa = 0; m_sb = 0;
                    m_win = 0; m_side = 0;
                end
        endcase
        m_pb = b; m_pstart = nstart; m_pa = na; m_pbm = nb;
        k++;
    endtask

    function automatic logic [14:0] mk(bit pl, bit pt, bit bt,
                                       bit sv, bit sb, int sa,
                                       int sbb, int w);
        return {pl, pt, bt, sv, sb, 4'(sa), 4'(sbb), 2'(w)};
    endfunction

    function automatic logic [14:0] got();
        return {playing, padTick, ballTick, serve, serveB,
                scoreA, scoreB, winner};
    endfunction

    function automatic logic [14:0] model_out();
        bit t, pl;
        t = m_tick();
        pl = (m_st == S_SERVE) || (m_st == S_PLAY) || (m_st == S_POINT);
        return mk(pl, t && (m_st == S_SERVE || m_st == S_PLAY),
                  t && (m_st == S_PLAY), m_serve, m_side,
                  m_sa, m_sb, int'(m_win));
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(bit r, bit b, bit ma, bit mb);
        @(negedge clk);
        rst = r; btnStart = b; missA = ma; missB = mb;
        @(posedge clk);
        model_edge(r, b, ma, mb);
        #1;
        if (serve === 1'b1) nserve++;
        chk("model", 32'(got()), 32'(model_out()));
    endtask

    task automatic wait_model(int target, int budget, string nm);
        int n = 0;
        while (m_st != target && n < budget) begin
            step(0, 1, 0, 0);
            n++;
        end
        chk(nm, 32'(m_st == target), 32'd1);
    endtask

    typedef struct {
        bit r, b, ma, mb;
        logic [14:0] exp;
    } vec_t;

    vec_t tbl[18];

    initial begin
        tbl[0]  = '{1, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{1, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[2]  = '{0, 1, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[3]  = '{0, 1, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[4]  = '{0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[5]  = '{0, 0, 0, 0, mk(1, 1, 0, 0, 0, 0, 0, 0)};
        tbl[6]  = '{0, 1, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0)};
        tbl[7]  = '{0, 1, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0)};
        tbl[8]  = '{0, 1, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0)};
        tbl[9]  = '{0, 1, 0, 0, mk(1, 1, 0, 0, 0, 0, 0, 0)};
        tbl[10] = '{0, 1, 0, 0, mk(1, 0, 0, 1, 0, 0, 0, 0)};
        tbl[11] = '{0, 1, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0)};
        tbl[12] = '{0, 1, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0)};
        tbl[13] = '{0, 1, 0, 0, mk(1, 1, 1, 0, 0, 0, 0, 0)};
        tbl[14] = '{0, 1, 1, 0, mk(1, 0, 0, 0, 0, 0, 0, 0)};
        tbl[15] = '{0, 1, 0, 0, mk(1, 0, 0, 0, 0, 0, 1, 0)};
        tbl[16] = '{0, 1, 0, 0, mk(1, 0, 0, 0, 0, 0, 1, 0)};
        tbl[17] = '{0, 1, 0, 0, mk(1, 1, 0, 0, 0, 0, 1, 0)};

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].r, tbl[i].b, tbl[i].ma, tbl[i].mb);
            chk($sformatf("vec%0d", i), 32'(got()), 32'(tbl[i].exp));
        end

        // Simultaneous misses: replay, no score change
        wait_model(S_PLAY, 60, "reach play simul");
        step(0, 1, 1, 1);
        step(0, 1, 0, 0);
        chk("simul scoreA", 32'(scoreA), 32'd0);
        chk("simul scoreB", 32'(scoreB), 32'd1);
        chk("simul serveB", 32'(serveB), 32'd0);
        step(0, 1, 0, 0);
        chk("simul ballTick", 32'(ballTick), 32'd0);

        // A wins with three points
        for (int i = 0; i < 3; i++) begin
            wait_model(S_PLAY, 60, "reach play win");
            step(0, 1, 0, 1);
            step(0, 1, 0, 0);
            chk("point scoreA", 32'(scoreA), 32'(i + 1));
            chk("point serveB", 32'(serveB), 32'd1);
            step(0, 1, 0, 0);
        end
        chk("win winner", 32'(winner), 32'd1);
        chk("win playing", 32'(playing), 32'd0);
        chk("win scoreA", 32'(scoreA), 32'd3);
        for (int i = 0; i < 4; i++) step(0, 1, 1, i[0]);
        chk("over hold scoreA", 32'(scoreA), 32'd3);
        chk("over hold scoreB", 32'(scoreB), 32'd1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("restart scoreA", 32'(scoreA), 32'd0);
        chk("restart winner", 32'(winner), 32'd0);
        chk("restart playing", 32'(playing), 32'd0);

        // Reset in the middle of the serve pause
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        nserve = 0;
        begin
            int n = 0;
            while (!(m_st == S_SERVE && m_pause == 1) && n < 60) begin
                step(0, 1, 0, 0);
                n++;
            end
            chk("reach pause1", 32'(n < 60), 32'd1);
        end
        step(1, 1, 0, 0);
        chk("midpause playing", 32'(playing), 32'd0);
        for (int i = 0; i < 20; i++) step(0, 1, 0, 0);
        chk("midpause no serve", 32'(nserve), 32'd0);
        chk("midpause idle", 32'(playing), 32'd0);

        // Random play against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom % 300 == 0, $urandom % 12 != 0,
                 $urandom % 20 == 0, $urandom % 20 == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
